// File: rtl/sd_cmd.sv
// sd_cmd: SD command-frame sequencer feeding the sdspi byte engine.
//
// Takes one SD command (index + 32-bit argument), asserts CS, sends an
// Ncs gap byte, the 6-byte frame with its CRC7, then polls for R1. For
// R3/R7-class commands it also collects the 4 payload bytes. Optionally
// sends a trailer byte and raises CS, then pulses cmdDone.
//
// Ports
//   clk, rst        clock; synchronous active-high reset (shared with sdspi)
//   cmdStart        one-cycle request, honoured only when idle
//   cmdIndex/Arg    command index and argument, latched on accept
//   cmdLong         collect a 4-byte payload after R1
//   cmdKeepCS       leave CS low at the end (a data phase follows)
//   cmdBusy         high from the cycle after accept until done
//   cmdDone         one-cycle completion pulse
//   cmdR1           R1 byte (0xFF on timeout)
//   cmdResp         payload, first received byte in [31:24]
//   cmdTimeout      no R1 within NcrMax polls
//   spiOP/spiTXD    registered operation and byte to sdspi
//   spiRXD/spiDONE  received byte and byte-complete strobe from sdspi

package sd_cmd_pkg;
    typedef enum logic [2:0] {
        spiNOP  = 3'd0,
        spiCSL  = 3'd1,
        spiCSH  = 3'd2,
        spiFAST = 3'd3,
        spiSLOW = 3'd4,
        spiTR   = 3'd5
    } spiOP_t;
endpackage

module sd_cmd
    import sd_cmd_pkg::*;
#(
    parameter int NcrMax = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmdStart,
    input  logic [5:0]  cmdIndex,
    input  logic [31:0] cmdArg,
    input  logic        cmdLong,
    input  logic        cmdKeepCS,
    output logic        cmdBusy,
    output logic        cmdDone,
    output logic [7:0]  cmdR1,
    output logic [31:0] cmdResp,
    output logic        cmdTimeout,
    output spiOP_t      spiOP,
    output logic [7:0]  spiTXD,
    input  logic [7:0]  spiRXD,
    input  logic        spiDONE
);

    localparam logic [3:0] NCR = 4'(NcrMax);

    typedef enum logic [3:0] {
        IDLE, CSL, PRE, FRAME, POLL, LONG, POST, CSH, DONE
    } state_t;

    state_t      r_state;
    logic [5:0]  r_idx;
    logic [31:0] r_arg;
    logic        r_long;
    logic        r_keep;
    logic [6:0]  r_crc;
    logic [2:0]  r_cnt;   // frame bytes issued / payload bytes issued
    logic [3:0]  r_poll;  // poll bytes issued

    logic [7:0]  w_frame_byte;
    logic        w_r1_ok;
    logic        w_to;
    logic        w_long_end;
    logic        w_fin;

    // CRC7 (x^7 + x^3 + 1) advanced over one byte, MSB first.
    function automatic logic [6:0] crc7_byte(input logic [6:0] c, input logic [7:0] b);
        logic [6:0] x;
        logic       fb;
        x = c;
        for (int i = 7; i >= 0; i--) begin
            fb = x[6] ^ b[i];
            x  = {x[5:0], 1'b0};
            if (fb) x = x ^ 7'h09;
        end
        return x;
    endfunction

    // Next frame byte after the command byte; r_cnt counts bytes already sent.
    always_comb begin
        w_frame_byte = {r_crc, 1'b1};
        case (r_cnt)
            3'd1:    w_frame_byte = r_arg[31:24];
            3'd2:    w_frame_byte = r_arg[23:16];
            3'd3:    w_frame_byte = r_arg[15:8];
            3'd4:    w_frame_byte = r_arg[7:0];
            default: w_frame_byte = {r_crc, 1'b1};
        endcase
    end

    // End-of-response events: R1 without payload, poll timeout, last payload byte.
    assign w_r1_ok    = spiDONE && (r_state == POLL) && !spiRXD[7];
    assign w_to       = spiDONE && (r_state == POLL) && spiRXD[7] && (r_poll == NCR);
    assign w_long_end = spiDONE && (r_state == LONG) && (r_cnt == 3'd4);
    assign w_fin      = (w_r1_ok && !r_long) || w_to || w_long_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_arg      <= '0;
            r_long     <= 1'b0;
            r_keep     <= 1'b0;
            r_crc      <= '0;
            r_cnt      <= '0;
            r_poll     <= '0;
            cmdBusy    <= 1'b0;
            cmdDone    <= 1'b0;
            cmdR1      <= 8'hFF;
            cmdResp    <= '0;
            cmdTimeout <= 1'b0;
            spiOP      <= spiNOP;
            spiTXD     <= 8'hFF;
        end else begin
            // Ops are single-cycle; spiTXD only changes when a transfer is issued.
            spiOP   <= spiNOP;
            cmdDone <= 1'b0;
            case (r_state)
                IDLE: if (cmdStart) begin
                    r_idx      <= cmdIndex;
                    r_arg      <= cmdArg;
                    r_long     <= cmdLong;
                    r_keep     <= cmdKeepCS;
                    r_crc      <= '0;
                    cmdResp    <= '0;
                    cmdTimeout <= 1'b0;
                    cmdR1      <= 8'hFF;
                    cmdBusy    <= 1'b1;
                    spiOP      <= spiCSL;
                    r_state    <= CSL;
                end
                CSL: begin
                    spiOP   <= spiTR;
                    spiTXD  <= 8'hFF;
                    r_state <= PRE;
                end
                PRE: if (spiDONE) begin
                    spiOP   <= spiTR;
                    spiTXD  <= {2'b01, r_idx};
                    r_crc   <= crc7_byte(7'd0, {2'b01, r_idx});
                    r_cnt   <= 3'd1;
                    r_state <= FRAME;
                end
                FRAME: if (spiDONE) begin
                    spiOP <= spiTR;
                    if (r_cnt == 3'd6) begin
                        spiTXD  <= 8'hFF;
                        r_poll  <= 4'd1;
                        r_state <= POLL;
                    end else begin
                        spiTXD <= w_frame_byte;
                        // The CRC byte itself is not folded into the CRC.
                        if (r_cnt != 3'd5) r_crc <= crc7_byte(r_crc, w_frame_byte);
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                POLL: if (spiDONE) begin
                    if (!spiRXD[7]) begin
                        cmdR1 <= spiRXD;
                        if (r_long) begin
                            spiOP   <= spiTR;
                            spiTXD  <= 8'hFF;
                            r_cnt   <= 3'd1;
                            r_state <= LONG;
                        end
                    end else if (r_poll != NCR) begin
                        spiOP  <= spiTR;
                        spiTXD <= 8'hFF;
                        r_poll <= r_poll + 4'd1;
                    end
                end
                LONG: if (spiDONE) begin
                    cmdResp <= {cmdResp[23:0], spiRXD};
                    if (r_cnt != 3'd4) begin
                        spiOP  <= spiTR;
                        spiTXD <= 8'hFF;
                        r_cnt  <= r_cnt + 3'd1;
                    end
                end
                POST: if (spiDONE) begin
                    spiOP   <= spiCSH;
                    r_state <= CSH;
                end
                CSH: begin
                    cmdDone <= 1'b1;
                    cmdBusy <= 1'b0;
                    r_state <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            // Response phase over: either finish with CS held low, or send the trailer.
            if (w_fin) begin
                if (r_keep) begin
                    cmdDone <= 1'b1;
                    cmdBusy <= 1'b0;
                    r_state <= DONE;
                end else begin
                    spiOP   <= spiTR;
                    spiTXD  <= 8'hFF;
                    r_state <= POST;
                end
            end
            if (w_to) cmdTimeout <= 1'b1;
        end
    end

endmodule

// File: doc/sd_cmd.md
# sd_cmd

SD command-frame sequencer that sits directly upstream of the RK8E SPI byte engine `sdspi` and drives its `spiOP`/`spiTXD` inputs. It accepts one SD command (index + 32-bit argument), generates the CRC7, shifts the 6-byte frame out, and polls for the R1 response. For R3/R7-class commands it also captures the 4 trailing response bytes. It reports completion, R1, optional 32-bit payload and NCR timeout to the RK8E disk controller state machine.

## Interface
- `NcrMax`, 8: maximum 0xFF poll bytes sent while waiting for R1 (1..15).
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high; shared with `sdspi`.
- `cmdStart`  in  1  one-cycle request; sampled only in IDLE.
- `cmdIndex`  in  6  SD command index; latched on accepted `cmdStart`.
- `cmdArg`  in  32  command argument; latched on accepted `cmdStart`.
- `cmdLong`  in  1  read a 4-byte payload after R1 (R3/R7); latched.
- `cmdKeepCS`  in  1  1 = leave CS low at end (a data phase follows); latched.
- `cmdBusy`  out  1  high from the cycle after accept until DONE.
- `cmdDone`  out  1  one-cycle completion pulse.
- `cmdR1`  out  8  R1 byte; 0xFF on timeout.
- `cmdResp`  out  32  payload, MSB first; valid with `cmdDone` when `cmdLong`=1.
- `cmdTimeout`  out  1  valid with `cmdDone`; high if no R1 within `NcrMax` polls.
- `spiOP`  out  spiOP_t  operation to `sdspi`; registered.
- `spiTXD`  out  8  byte to `sdspi`; registered, held stable while a transfer is in progress.
- `spiRXD`  in  8  received byte from `sdspi`.
- `spiDONE`  in  1  one-cycle byte-complete strobe from `sdspi`.

## Operation
- States: IDLE, CSL, PRE, FRAME, POLL, LONG, POST, CSH, DONE.
- Op issue: every `spiOP` other than spiNOP is driven for exactly one cycle, then spiNOP. After a spiTR, wait for `spiDONE`. Sample `spiRXD` in the `spiDONE` cycle. Issue the next op no earlier than the cycle after `spiDONE`.
- IDLE: when `cmdStart`=1, latch the inputs, clear `cmdResp`/`cmdTimeout`, set `cmdR1`=0xFF, and go to CSL.
- CSL: issue spiCSL for one cycle, then go to PRE.
- PRE: issue spiTR with 0xFF (Ncs gap byte), then go to FRAME.
- FRAME: send 6 bytes in order:
  - 0x40|index;
  - arg[31:24], arg[23:16], arg[15:8], arg[7:0];
  - {crc7, 1'b1}.
  - 3-bit byte counter.
- CRC7: polynomial x^7+x^3+1, initial value 0. Update over each of the first 5 bytes, MSB first, in the cycle that byte is loaded.
- POLL: send 0xFF and count polls.
  - On `spiDONE` with `spiRXD[7]`=0: latch `cmdR1`, then go to LONG if `cmdLong`=1, else POST.
  - On `spiDONE` of poll number `NcrMax` with `spiRXD[7]`=1: set `cmdTimeout`=1, leave `cmdR1`=0xFF, skip LONG, go to POST.
- LONG: send four 0xFF bytes. Shift each received byte into `cmdResp` from the LSB end, so the first byte lands in [31:24].
- POST:
  - `cmdKeepCS`=0: send one 0xFF trailer byte, then go to CSH.
  - `cmdKeepCS`=1: go straight to DONE with CS still low.
- CSH: issue spiCSH for one cycle, then go to DONE.
- DONE: pulse `cmdDone` for one cycle, drop `cmdBusy`, return to IDLE.
- `cmdStart` while not IDLE is ignored with no side effect.
- The block never issues spiFAST/spiSLOW; clock rate is the controller's responsibility while this block is idle.

## Timing
- Reset values: `spiOP`=spiNOP, `spiTXD`=0xFF, `cmdBusy`=0, `cmdDone`=0, `cmdR1`=0xFF, `cmdResp`=0, `cmdTimeout`=0; state IDLE.
- Reset mid-command: abandon immediately. `sdspi` is reset by the same `rst` and raises CS itself; no CSH op is issued.
- Accepting `cmdStart` in cycle N gives `cmdBusy`=1 and `spiOP`=spiCSL in cycle N+1.
- A spiTR is issued in the cycle after the CSL op, and in the cycle after each `spiDONE`. There are no dead cycles beyond that one.
- `cmdDone` rises the cycle after the last `spiDONE`, or two cycles after it when CSH is issued.
- Transfer count per command: 1 (PRE) + 6 (FRAME) + k polls (1..`NcrMax`) + 4 if long + 1 if not keep-CS.
- `spiOP` must be spiNOP during every `spiDONE` cycle, so `sdspi` never re-triggers.

## Test plan
- CMD0, arg 0x00000000, `sdspi` model returns 0xFF,0x01 on polls -> frame 40 00 00 00 00 95; `cmdR1`=0x01; `cmdTimeout`=0; CSL/CSH each one cycle; `cmdDone` one pulse.
- CMD8, arg 0x000001AA, `cmdLong`=1, responses 0x01,0x00,0x00,0x01,0xAA -> frame ends 0x87; `cmdResp`=0x000001AA; `cmdR1`=0x01.
- CMD0, MISO always 0xFF, `NcrMax`=8 -> exactly 8 poll transfers; `cmdTimeout`=1; `cmdR1`=0xFF; trailer byte and CSH still issued.
- CMD17, `cmdKeepCS`=1, R1=0x00 first poll -> no trailer, no spiCSH; `cmdDone` the cycle after the R1 `spiDONE`.
- `cmdStart` re-pulsed mid-FRAME; `rst` asserted during POLL -> second start ignored with frame unchanged; after reset all outputs at reset values, and a new CMD0 completes normally.
